// File: rtl/aes_pkg.sv
// Shared AES-128 constants, controller state encoding and the GF(2^8) round helpers
// reused by both cipher directions.
package aes_pkg;

  localparam int unsigned NR = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_MIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant (09/0b/0d/0e) as a sum of xtime powers.
  function automatic logic [7:0] gf_mul_c(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = gf_xtime(b);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    return (c[3] ? x8 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^
           (c[1] ? x2 : 8'h00) ^ (c[0] ? b  : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {gf_mul_c(a0, 4'he) ^ gf_mul_c(a1, 4'hb) ^ gf_mul_c(a2, 4'hd) ^ gf_mul_c(a3, 4'h9),
            gf_mul_c(a0, 4'h9) ^ gf_mul_c(a1, 4'he) ^ gf_mul_c(a2, 4'hb) ^ gf_mul_c(a3, 4'hd),
            gf_mul_c(a0, 4'hd) ^ gf_mul_c(a1, 4'h9) ^ gf_mul_c(a2, 4'he) ^ gf_mul_c(a3, 4'hb),
            gf_mul_c(a0, 4'hb) ^ gf_mul_c(a1, 4'hd) ^ gf_mul_c(a2, 4'h9) ^ gf_mul_c(a3, 4'he)};
  endfunction

  // Row r rotates right by r; b[15-i] is state byte i.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [15:0][7:0] b;
    b = s;
    return {b[15-0],  b[15-13], b[15-10], b[15-7],
            b[15-4],  b[15-1],  b[15-14], b[15-11],
            b[15-8],  b[15-5],  b[15-2],  b[15-15],
            b[15-12], b[15-9],  b[15-6],  b[15-3]};
  endfunction

endpackage

// File: rtl/inv_sub_lanes.sv
// LANES parallel AES inverse S-box lookups on a packed byte bus; purely combinational.
module inv_sub_lanes #(
  parameter int unsigned LANES = 4
) (
  input  logic [LANES*8-1:0] in_bytes,
  output logic [LANES*8-1:0] out_bytes_c
);

  localparam logic [0:255][7:0] INV_SBOX = {
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign out_bytes_c[i*8 +: 8] = INV_SBOX[in_bytes[i*8 +: 8]];
  end

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES-128 decryption controller: one 128-bit state register, LANES shared
// inverse S-boxes, round keys fetched by index from an external key store.
module aes_inv_cipher_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy
);

  localparam int unsigned SUBC = 16 / LANES;
  localparam int unsigned GW   = (SUBC > 1) ? $clog2(SUBC) : 1;
  localparam int unsigned LW   = LANES * 8;
  localparam logic [127:0] LANE_MASK = 128'({LW{1'b1}});

  state_e          state_q, state_d;
  logic [127:0]    blk_q, blk_d;
  logic [3:0]      round_q, round_d;
  logic [GW-1:0]   grp_q, grp_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic [3:0]      rk_idx_q, rk_idx_d;

  logic [6:0]      sub_sh;
  logic [LW-1:0]   sub_in, sub_out;
  logic [127:0]    shifted;
  logic [3:0][31:0] cols;
  logic [127:0]    mixed;

  // Byte-group select: group g occupies bytes g*LANES.. counted from the MSB end.
  always_comb begin
    sub_sh  = 7'((SUBC - 1 - 32'(grp_q)) * LW);
    sub_in  = LW'(blk_q >> sub_sh);
    shifted = inv_shift_rows(blk_q) ^ rk;
    cols    = shifted;
    mixed   = {inv_mix_column(cols[3]), inv_mix_column(cols[2]),
               inv_mix_column(cols[1]), inv_mix_column(cols[0])};
  end

  inv_sub_lanes #(.LANES(LANES)) u_inv_sub_lanes (
    .in_bytes    (sub_in),
    .out_bytes_c (sub_out)
  );

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    round_d = round_q;
    grp_d   = grp_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          blk_d   = in_block ^ rk;
          round_d = 4'(NR - 1);
          grp_d   = '0;
          state_d = ST_SUB;
        end
      end
      ST_SUB: begin
        blk_d = (blk_q & ~(LANE_MASK << sub_sh)) | (128'(sub_out) << sub_sh);
        if (grp_q == GW'(SUBC - 1)) begin
          grp_d   = '0;
          state_d = ST_MIX;
        end else begin
          grp_d = grp_q + GW'(1);
        end
      end
      ST_MIX: begin
        if (round_q != 4'd0) begin
          blk_d   = mixed;
          round_d = round_q - 4'd1;
          grp_d   = '0;
          state_d = ST_SUB;
        end else begin
          blk_d   = shifted;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so nothing leaks combinationally.
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d == ST_SUB) || (state_d == ST_MIX);
    rk_idx_d    = (state_d == ST_IDLE) ? 4'(NR) : round_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      blk_q       <= '0;
      round_q     <= '0;
      grp_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rk_idx_q    <= 4'(NR);
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      round_q     <= round_d;
      grp_q       <= grp_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      rk_idx_q    <= rk_idx_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign rk_idx    = rk_idx_q;
  assign out_block = blk_q;

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Directed bench for aes_inv_cipher_ctrl: FIPS-197 vectors, backpressure, back-to-back,
// mid-operation reset and LANES=1/16 latency on parallel instances.
module tb_aes_inv_cipher_ctrl;

  localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_APPB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_APPB = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, out_ready, key_sel;
  logic [127:0] in_block;
  logic         in_ready, out_valid, busy;
  logic [3:0]   rk_idx;
  logic [127:0] rk, out_block;

  logic         sv_in_valid;
  logic [127:0] sv_in_block;
  logic         l1_in_ready, l1_out_valid, l1_busy, l16_in_ready, l16_out_valid, l16_busy;
  logic [3:0]   l1_rk_idx, l16_rk_idx;
  logic [127:0] l1_rk, l16_rk, l1_out_block, l16_out_block;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Precomputed key schedules: ks=0 is key 000102..0f, ks=1 is key 2b7e1516..4f3c.
  function automatic logic [127:0] round_key(input logic ks, input logic [3:0] idx);
    logic [127:0] k;
    k = '0;
    if (!ks) begin
      case (idx)
        4'd0:  k = 128'h000102030405060708090a0b0c0d0e0f;
        4'd1:  k = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        4'd2:  k = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        4'd3:  k = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        4'd4:  k = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        4'd5:  k = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        4'd6:  k = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        4'd7:  k = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        4'd8:  k = 128'h47438735a41c65b9e016baf4aebf7ad2;
        4'd9:  k = 128'h549932d1f08557681093ed9cbe2c974e;
        4'd10: k = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        default: k = '0;
      endcase
    end else begin
      case (idx)
        4'd0:  k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        4'd1:  k = 128'ha0fafe1788542cb123a339392a6c7605;
        4'd2:  k = 128'hf2c295f27a96b9435935807a7359f67f;
        4'd3:  k = 128'h3d80477d4716fe3e1e237e446d7a883b;
        4'd4:  k = 128'hef44a541a8525b7fb671253bdb0bad00;
        4'd5:  k = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        4'd6:  k = 128'h6d88a37a110b3efddbf98641ca0093fd;
        4'd7:  k = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        4'd8:  k = 128'head27321b58dbad2312bf5607f8d292f;
        4'd9:  k = 128'hac7766f319fadc2128d12941575c006e;
        4'd10: k = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        default: k = '0;
      endcase
    end
    return k;
  endfunction

  always_comb rk     = round_key(key_sel, rk_idx);
  always_comb l1_rk  = round_key(1'b0, l1_rk_idx);
  always_comb l16_rk = round_key(1'b0, l16_rk_idx);

  aes_inv_cipher_ctrl #(.LANES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .rk_idx(rk_idx), .rk(rk), .out_valid(out_valid),
    .out_ready(out_ready), .out_block(out_block), .busy(busy)
  );

  aes_inv_cipher_ctrl #(.LANES(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sv_in_valid), .in_ready(l1_in_ready),
    .in_block(sv_in_block), .rk_idx(l1_rk_idx), .rk(l1_rk), .out_valid(l1_out_valid),
    .out_ready(1'b1), .out_block(l1_out_block), .busy(l1_busy)
  );

  aes_inv_cipher_ctrl #(.LANES(16)) u_dut_l16 (
    .clk(clk), .rst_n(rst_n), .in_valid(sv_in_valid), .in_ready(l16_in_ready),
    .in_block(sv_in_block), .rk_idx(l16_rk_idx), .rk(l16_rk), .out_valid(l16_out_valid),
    .out_ready(1'b1), .out_block(l16_out_block), .busy(l16_busy)
  );

  // Bounded wait from the negedge after the accept edge; k = edges since acceptance.
  task automatic wait_out(output int k);
    k = 0;
    while (out_valid !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; key_sel = 1'b0; in_block = '0;
    sv_in_valid = 1'b0; sv_in_block = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rk_idx !== 4'd10) begin failures++; $display("FAIL reset_rk_idx got=%0d exp=10", rk_idx); end
    checks++; if (out_block !== 128'h0) begin failures++; $display("FAIL reset_out_block got=%h exp=0", out_block); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL post_reset_idle in_ready=%b busy=%b exp 1/0", in_ready, busy); end
  endtask

  task automatic test_c1();
    int k;
    key_sel = 1'b0; in_block = CT_C1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL c1_accept busy=%b in_ready=%b exp 1/0", busy, in_ready); end
    wait_out(k);
    checks++; if (k !== 50) begin failures++; $display("FAIL c1_latency got=%0d exp=50", k); end
    checks++; if (out_block !== PT_C1) begin failures++; $display("FAIL c1_plaintext got=%h exp=%h", out_block, PT_C1); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL c1_handshake out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready); end
  endtask

  task automatic test_app_b_rk_seq();
    logic [3:0] exp_idx;
    key_sel = 1'b1; in_block = CT_APPB; out_ready = 1'b1;
    checks++; if (rk_idx !== 4'd10) begin failures++; $display("FAIL appb_rk_idle got=%0d exp=10", rk_idx); end
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 50; k++) begin
      exp_idx = 4'(9 - k / 5);
      checks++; if (rk_idx !== exp_idx) begin failures++; $display("FAIL appb_rk_idx cycle=%0d got=%0d exp=%0d", k, rk_idx, exp_idx); end
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL appb_valid_at_50 got=%b exp=1", out_valid); end
    checks++; if (out_block !== PT_APPB) begin failures++; $display("FAIL appb_plaintext got=%h exp=%h", out_block, PT_APPB); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || rk_idx !== 4'd10) begin failures++; $display("FAIL appb_return_idle out_valid=%b rk_idx=%0d exp 0/10", out_valid, rk_idx); end
  endtask

  task automatic test_backpressure();
    int k;
    key_sel = 1'b0; in_block = CT_C1; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(k);
    checks++; if (k !== 50) begin failures++; $display("FAIL bp_latency got=%0d exp=50", k); end
    in_block = CT_APPB; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_block !== PT_C1) begin failures++; $display("FAIL bp_hold cycle=%0d out_valid=%b out_block=%h exp 1/%h", i, out_valid, out_block, PT_C1); end
      checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bp_no_accept cycle=%0d in_ready=%b busy=%b exp 0/0", i, in_ready, busy); end
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_second_ignored busy=%b in_ready=%b exp 0/1", busy, in_ready); end
  endtask

  task automatic test_back_to_back();
    int k1, k2;
    key_sel = 1'b0; in_block = CT_C1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_first_accept in_ready=%b exp=0", in_ready); end
    in_block = CT_APPB;
    wait_out(k1);
    checks++; if (k1 !== 50) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=50", k1); end
    checks++; if (out_block !== PT_C1) begin failures++; $display("FAIL b2b_first_pt got=%h exp=%h", out_block, PT_C1); end
    key_sel = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL b2b_gap out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL b2b_second_accept_52 in_ready=%b busy=%b exp 0/1", in_ready, busy); end
    in_valid = 1'b0;
    wait_out(k2);
    checks++; if (k2 !== 50) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=50", k2); end
    checks++; if (out_block !== PT_APPB) begin failures++; $display("FAIL b2b_second_pt got=%h exp=%h", out_block, PT_APPB); end
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    int seen;
    key_sel = 1'b0; in_block = CT_C1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (23) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_flags in_ready=%b out_valid=%b busy=%b exp 1/0/0", in_ready, out_valid, busy); end
    checks++; if (rk_idx !== 4'd10 || out_block !== 128'h0) begin failures++; $display("FAIL midrst_data rk_idx=%0d out_block=%h exp 10/0", rk_idx, out_block); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1 || busy === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_no_output active_cycles=%0d exp=0", seen); end
  endtask

  task automatic test_lane_sweep();
    int lat1, lat16;
    logic [127:0] pt1, pt16;
    lat1 = -1; lat16 = -1; pt1 = '0; pt16 = '0;
    sv_in_block = CT_C1; sv_in_valid = 1'b1;
    @(negedge clk);
    sv_in_valid = 1'b0;
    checks++; if (l1_in_ready !== 1'b0 || l16_in_ready !== 1'b0) begin failures++; $display("FAIL sweep_accept l1=%b l16=%b exp 0/0", l1_in_ready, l16_in_ready); end
    for (int k = 0; k <= 200; k++) begin
      if (l1_out_valid === 1'b1 && lat1 < 0) begin lat1 = k; pt1 = l1_out_block; end
      if (l16_out_valid === 1'b1 && lat16 < 0) begin lat16 = k; pt16 = l16_out_block; end
      if (lat1 >= 0 && lat16 >= 0) break;
      @(negedge clk);
    end
    checks++; if (lat1 !== 170) begin failures++; $display("FAIL sweep_l1_latency got=%0d exp=170", lat1); end
    checks++; if (pt1 !== PT_C1) begin failures++; $display("FAIL sweep_l1_pt got=%h exp=%h", pt1, PT_C1); end
    checks++; if (lat16 !== 20) begin failures++; $display("FAIL sweep_l16_latency got=%0d exp=20", lat16); end
    checks++; if (pt16 !== PT_C1) begin failures++; $display("FAIL sweep_l16_pt got=%h exp=%h", pt16, PT_C1); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_c1();
    test_app_b_rk_seq();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    test_c1();
    test_lane_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
